// File: rtl/cve2_hwloop_bank.sv
// cve2_hwloop_bank: hardware-loop start/end/count bank with end-of-loop detection and branch-back
module cve2_hwloop_bank #(
  parameter int unsigned N_LOOPS = 2,
  parameter int unsigned ADDR_W  = 32,
  parameter int unsigned CNT_W   = 32,
  parameter int unsigned ALIGN   = 2,
  localparam int unsigned ID_W   = N_LOOPS > 1 ? $clog2(N_LOOPS) : 1
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic [2:0]                  we_i,
  input  logic [ID_W-1:0]             regid_i,
  input  logic [ADDR_W-1:0]           start_data_i,
  input  logic [ADDR_W-1:0]           end_data_i,
  input  logic [CNT_W-1:0]            cnt_data_i,
  input  logic                        pc_valid_i,
  input  logic [ADDR_W-1:0]           pc_i,
  output logic                        jump_o,
  output logic [ADDR_W-1:0]           jump_target_o,
  output logic [ID_W-1:0]             jump_id_o,
  output logic [N_LOOPS-1:0]          active_o,
  output logic [N_LOOPS-1:0]          last_iter_o,
  output logic [N_LOOPS*ADDR_W-1:0]   start_addr_o,
  output logic [N_LOOPS*ADDR_W-1:0]   end_addr_o,
  output logic [N_LOOPS*CNT_W-1:0]    counter_o
);
  localparam logic [ADDR_W-1:0] MASK = ~((ADDR_W'(1) << ALIGN) - ADDR_W'(1));
  logic [ADDR_W-1:0] start_q [N_LOOPS];
  logic [ADDR_W-1:0] end_q   [N_LOOPS];
  logic [CNT_W-1:0]  cnt_q   [N_LOOPS];
  logic [N_LOOPS-1:0] match;
  logic hit;
  logic [ID_W-1:0] win;
  genvar i;
  for (i = 0; i < N_LOOPS; i++) begin : g_loop
    assign match[i] = pc_valid_i && cnt_q[i] != '0 && pc_i == end_q[i];
    assign active_o[i] = cnt_q[i] != '0;
    assign last_iter_o[i] = cnt_q[i] == CNT_W'(1);
    assign start_addr_o[i*ADDR_W +: ADDR_W] = start_q[i];
    assign end_addr_o[i*ADDR_W +: ADDR_W] = end_q[i];
    assign counter_o[i*CNT_W +: CNT_W] = cnt_q[i];
  end
  // lowest-index matching loop wins (innermost loop first)
  always_comb begin
    hit = 1'b0;
    win = '0;
    for (int k = N_LOOPS - 1; k >= 0; k--)
      if (match[k]) begin
        hit = 1'b1;
        win = ID_W'(k);
      end
  end
  assign jump_o = hit && cnt_q[win] > CNT_W'(1);
  assign jump_target_o = hit ? start_q[win] : '0;
  assign jump_id_o = hit ? win : '0;
  // register writes; a count write overrides the winner's decrement
  always_ff @(posedge clk) begin
    for (int k = 0; k < N_LOOPS; k++)
      if (rst) begin
        start_q[k] <= '0;
        end_q[k] <= '0;
        cnt_q[k] <= '0;
      end else begin
        if (we_i[0] && regid_i == ID_W'(k)) start_q[k] <= start_data_i & MASK;
        if (we_i[1] && regid_i == ID_W'(k)) end_q[k] <= end_data_i & MASK;
        if (we_i[2] && regid_i == ID_W'(k)) cnt_q[k] <= cnt_data_i;
        else if (hit && win == ID_W'(k)) cnt_q[k] <= cnt_q[k] - CNT_W'(1);
      end
  end
endmodule

// File: tb/tb_cve2_hwloop_bank.sv
// tb_cve2_hwloop_bank: directed self-checking bench for the hardware-loop bank
module tb_cve2_hwloop_bank;
  localparam int N = 3;
  logic clk = 0, rst = 1;
  logic [2:0] we_i = 0;
  logic [1:0] regid_i = 0;
  logic [31:0] start_data_i = 0, end_data_i = 0, cnt_data_i = 0, pc_i = 0;
  logic pc_valid_i = 0;
  logic jump_o;
  logic [31:0] jump_target_o;
  logic [1:0] jump_id_o;
  logic [N-1:0] active_o, last_iter_o;
  logic [N*32-1:0] start_addr_o, end_addr_o, counter_o;
  int n_cmp = 0, n_err = 0;
  cve2_hwloop_bank #(.N_LOOPS(N), .ADDR_W(32), .CNT_W(32), .ALIGN(2)) dut (
    .clk(clk), .rst(rst), .we_i(we_i), .regid_i(regid_i),
    .start_data_i(start_data_i), .end_data_i(end_data_i), .cnt_data_i(cnt_data_i),
    .pc_valid_i(pc_valid_i), .pc_i(pc_i), .jump_o(jump_o), .jump_target_o(jump_target_o),
    .jump_id_o(jump_id_o), .active_o(active_o), .last_iter_o(last_iter_o),
    .start_addr_o(start_addr_o), .end_addr_o(end_addr_o), .counter_o(counter_o)
  );
  always #5 clk = ~clk;
  task automatic tick();
    @(posedge clk);
    #1;
  endtask
  task automatic chk(input string tag, input logic [95:0] o, input logic [95:0] e);
    n_cmp++;
    if (o !== e) begin
      n_err++;
      $error("FAIL %s: got %h expected %h", tag, o, e);
    end
  endtask
  task automatic wr(input logic [2:0] we, input logic [1:0] id, input logic [31:0] s, input logic [31:0] e, input logic [31:0] c);
    we_i = we; regid_i = id; start_data_i = s; end_data_i = e; cnt_data_i = c;
    tick();
    we_i = 0;
  endtask
  initial begin
    tick(); tick();
    rst = 0;
    #1;
    chk("rst_active", active_o, 3'b000);
    chk("rst_last", last_iter_o, 3'b000);
    chk("rst_jump", jump_o, 1'b0);
    chk("rst_target", jump_target_o, 32'h0);
    chk("rst_id", jump_id_o, 2'd0);
    chk("rst_start", start_addr_o, 96'h0);
    chk("rst_end", end_addr_o, 96'h0);
    chk("rst_cnt", counter_o, 96'h0);
    pc_valid_i = 1; pc_i = 0;
    #1;
    chk("inactive_nojump", jump_o, 1'b0);
    pc_valid_i = 0;
    wr(3'b111, 0, 32'h100, 32'h10C, 32'd3);
    pc_valid_i = 1; pc_i = 32'h10C;
    #1;
    chk("l0_jump1", jump_o, 1'b1);
    chk("l0_target", jump_target_o, 32'h100);
    chk("l0_id", jump_id_o, 2'd0);
    chk("l0_active", active_o[0], 1'b1);
    tick();
    chk("l0_cnt2", counter_o[31:0], 32'd2);
    chk("l0_jump2", jump_o, 1'b1);
    tick();
    chk("l0_cnt1", counter_o[31:0], 32'd1);
    chk("l0_last", last_iter_o[0], 1'b1);
    chk("l0_jump3", jump_o, 1'b0);
    tick();
    chk("l0_cnt0", counter_o[31:0], 32'd0);
    chk("l0_inactive", active_o[0], 1'b0);
    chk("l0_nojump_after", jump_o, 1'b0);
    pc_valid_i = 0;
    wr(3'b110, 0, 32'h0, 32'h200, 32'd2);
    wr(3'b110, 1, 32'h0, 32'h200, 32'd5);
    pc_valid_i = 1; pc_i = 32'h200;
    #1;
    chk("prio_jump", jump_o, 1'b1);
    chk("prio_id", jump_id_o, 2'd0);
    chk("prio_target", jump_target_o, 32'h100);
    tick();
    pc_valid_i = 0;
    chk("prio_cnt0", counter_o[31:0], 32'd1);
    chk("prio_cnt1", counter_o[63:32], 32'd5);
    wr(3'b100, 0, 32'h0, 32'h0, 32'd4);
    pc_valid_i = 1; pc_i = 32'h200;
    we_i = 3'b101; regid_i = 0; start_data_i = 32'h300; cnt_data_i = 32'd9;
    #1;
    chk("coll_jump", jump_o, 1'b1);
    chk("coll_old_start", jump_target_o, 32'h100);
    tick();
    we_i = 0; pc_valid_i = 0;
    chk("coll_cnt_write_wins", counter_o[31:0], 32'd9);
    chk("coll_new_start", start_addr_o[31:0], 32'h300);
    wr(3'b001, 0, 32'h103, 32'h0, 32'h0);
    chk("align_start", start_addr_o[31:0], 32'h100);
    wr(3'b111, 3, 32'hDEAD_BEEF, 32'h1234_5678, 32'd77);
    chk("oor_start", start_addr_o, {32'h0, 32'h0, 32'h100});
    chk("oor_end", end_addr_o, {32'h0, 32'h200, 32'h200});
    chk("oor_cnt", counter_o, {32'd0, 32'd5, 32'd9});
    wr(3'b111, 0, 32'h100, 32'h200, 32'd7);
    pc_valid_i = 1; pc_i = 32'h200;
    #1;
    chk("mid_jump_before", jump_o, 1'b1);
    rst = 1;
    tick();
    rst = 0;
    #1;
    chk("mid_cnt", counter_o, 96'h0);
    chk("mid_active", active_o, 3'b000);
    chk("mid_jump_after", jump_o, 1'b0);
    pc_valid_i = 0;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
